alu_share_arbiter: RTL and testbench

//  Shares one combinational alu instance between two requesters, e.g. the main execute path and the branch/address unit.

---
 rtl/alu_share_arbiter_if.sv | 24 ++
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response port bundle for one alu_share_arbiter requester
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [OPW-1:0]   req_op;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-port arbiter sharing one combinational alu, registered per-port results
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int OPW        = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave port0,
    alu_share_arbiter_if.slave port1,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [OPW-1:0]     alu_opcode,
    input  logic [WIDTH-1:0]   alu_result,
    output logic [15:0]        conflict_cnt
);
    // rr_q = 0 means port0 wins the next contended cycle
    logic             rr_q, rr_d;
    logic             resp0_valid_q, resp0_valid_d;
    logic             resp1_valid_q, resp1_valid_d;
    logic [WIDTH-1:0] resp0_result_q, resp0_result_d;
    logic [WIDTH-1:0] resp1_result_q, resp1_result_d;
    logic [15:0]      conflict_cnt_q, conflict_cnt_d;

    logic elig0, elig1, conflict, grant0, grant1;

    always_comb begin
        elig0    = port0.req_valid & (~resp0_valid_q | port0.resp_ready);
        elig1    = port1.req_valid & (~resp1_valid_q | port1.resp_ready);
        conflict = elig0 & elig1;
        grant0   = 1'b0;
        grant1   = 1'b0;
        // rst is asynchronous, so grants are masked combinationally as well
        if (!rst) begin
            if (conflict) begin
                if ((FIXED_PRIO != 0) || !rr_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    // Idle alu inputs are parked at zero so the alu does not toggle
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        if (grant0) begin
            alu_a      = port0.req_a;
            alu_b      = port0.req_b;
            alu_opcode = port0.req_op;
        end else if (grant1) begin
            alu_a      = port1.req_a;
            alu_b      = port1.req_b;
            alu_opcode = port1.req_op;
        end
    end

    always_comb begin
        rr_d           = rr_q;
        resp0_valid_d  = resp0_valid_q;
        resp0_result_d = resp0_result_q;
        resp1_valid_d  = resp1_valid_q;
        resp1_result_d = resp1_result_q;
        conflict_cnt_d = conflict_cnt_q;

        if (grant0) begin
            rr_d = 1'b1;
        end else if (grant1) begin
            rr_d = 1'b0;
        end

        if (grant0) begin
            resp0_valid_d  = 1'b1;
            resp0_result_d = alu_result;
        end else if (port0.resp_ready) begin
            resp0_valid_d  = 1'b0;
        end

        if (grant1) begin
            resp1_valid_d  = 1'b1;
            resp1_result_d = alu_result;
        end else if (port1.resp_ready) begin
            resp1_valid_d  = 1'b0;
        end

        if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q           <= 1'b0;
            resp0_valid_q  <= 1'b0;
            resp0_result_q <= '0;
            resp1_valid_q  <= 1'b0;
            resp1_result_q <= '0;
            conflict_cnt_q <= 16'd0;
        end else begin
            rr_q           <= rr_d;
            resp0_valid_q  <= resp0_valid_d;
            resp0_result_q <= resp0_result_d;
            resp1_valid_q  <= resp1_valid_d;
            resp1_result_q <= resp1_result_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign port0.req_ready   = grant0;
    assign port1.req_ready   = grant1;
    assign port0.resp_valid  = resp0_valid_q;
    assign port0.resp_result = resp0_result_q;
    assign port1.resp_valid  = resp1_valid_q;
    assign port1.resp_result = resp1_result_q;
    assign conflict_cnt      = conflict_cnt_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter (round-robin and fixed-priority instances)
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // shared request-side stimulus, index = port
    logic        in_v  [2];
    logic [31:0] in_a  [2];
    logic [31:0] in_b  [2];
    logic [7:0]  in_op [2];
    logic        in_rr [2];

    // observed outputs, first index = dut (0 round-robin, 1 fixed priority)
    logic        o_rdy [2][2];
    logic        o_rv  [2][2];
    logic [31:0] o_res [2][2];
    logic [31:0] o_alua [2];
    logic [31:0] o_alub [2];
    logic [7:0]  o_aluop [2];
    logic [31:0] alu_res [2];
    logic [15:0] o_cnt [2];

    alu_share_arbiter_if #(.WIDTH(32), .OPW(8)) p0_rr ();
    alu_share_arbiter_if #(.WIDTH(32), .OPW(8)) p1_rr ();
    alu_share_arbiter_if #(.WIDTH(32), .OPW(8)) p0_fp ();
    alu_share_arbiter_if #(.WIDTH(32), .OPW(8)) p1_fp ();

    assign p0_rr.req_valid = in_v[0];  assign p0_rr.req_a = in_a[0];  assign p0_rr.req_b = in_b[0];
    assign p0_rr.req_op = in_op[0];    assign p0_rr.resp_ready = in_rr[0];
    assign p1_rr.req_valid = in_v[1];  assign p1_rr.req_a = in_a[1];  assign p1_rr.req_b = in_b[1];
    assign p1_rr.req_op = in_op[1];    assign p1_rr.resp_ready = in_rr[1];
    assign p0_fp.req_valid = in_v[0];  assign p0_fp.req_a = in_a[0];  assign p0_fp.req_b = in_b[0];
    assign p0_fp.req_op = in_op[0];    assign p0_fp.resp_ready = in_rr[0];
    assign p1_fp.req_valid = in_v[1];  assign p1_fp.req_a = in_a[1];  assign p1_fp.req_b = in_b[1];
    assign p1_fp.req_op = in_op[1];    assign p1_fp.resp_ready = in_rr[1];

    assign o_rdy[0][0] = p0_rr.req_ready;  assign o_rdy[0][1] = p1_rr.req_ready;
    assign o_rdy[1][0] = p0_fp.req_ready;  assign o_rdy[1][1] = p1_fp.req_ready;
    assign o_rv[0][0]  = p0_rr.resp_valid; assign o_rv[0][1]  = p1_rr.resp_valid;
    assign o_rv[1][0]  = p0_fp.resp_valid; assign o_rv[1][1]  = p1_fp.resp_valid;
    assign o_res[0][0] = p0_rr.resp_result; assign o_res[0][1] = p1_rr.resp_result;
    assign o_res[1][0] = p0_fp.resp_result; assign o_res[1][1] = p1_fp.resp_result;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        case (op)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return a & b;
            8'd3:    return a | b;
            8'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_res[0] = alu_f(o_alua[0], o_alub[0], o_aluop[0]);
    assign alu_res[1] = alu_f(o_alua[1], o_alub[1], o_aluop[1]);

    alu_share_arbiter #(.WIDTH(32), .OPW(8), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .port0(p0_rr), .port1(p1_rr),
        .alu_a(o_alua[0]), .alu_b(o_alub[0]), .alu_opcode(o_aluop[0]),
        .alu_result(alu_res[0]), .conflict_cnt(o_cnt[0])
    );

    alu_share_arbiter #(.WIDTH(32), .OPW(8), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .port0(p0_fp), .port1(p1_fp),
        .alu_a(o_alua[1]), .alu_b(o_alub[1]), .alu_opcode(o_aluop[1]),
        .alu_result(alu_res[1]), .conflict_cnt(o_cnt[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-dut slot contents, preferred port and contention tally
    logic        m_v   [2][2];
    logic [31:0] m_r   [2][2];
    int          m_pref [2];
    int          m_cnt [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pref[d] = 0;
            m_cnt[d]  = 0;
            for (int p = 0; p < 2; p++) begin
                m_v[d][p] = 1'b0;
                m_r[d][p] = 32'd0;
            end
        end
    endtask

    function automatic bit elig(input int d, input int p);
        return in_v[p] && (!m_v[d][p] || in_rr[p]);
    endfunction

    function automatic int exp_grant(input int d);
        if (elig(d, 0) && elig(d, 1)) return (d == 1) ? 0 : m_pref[d];
        if (elig(d, 0)) return 0;
        if (elig(d, 1)) return 1;
        return -1;
    endfunction

    task automatic model_check();
        for (int d = 0; d < 2; d++) begin
            int g;
            logic [31:0] ea, eb;
            logic [7:0]  eo;
            g  = exp_grant(d);
            ea = 32'd0; eb = 32'd0; eo = 8'd0;
            if (g >= 0) begin
                ea = in_a[g]; eb = in_b[g]; eo = in_op[g];
            end
            chk1($sformatf("rnd d%0d req0_ready", d), o_rdy[d][0], g == 0);
            chk1($sformatf("rnd d%0d req1_ready", d), o_rdy[d][1], g == 1);
            chk32($sformatf("rnd d%0d alu_a", d), o_alua[d], ea);
            chk32($sformatf("rnd d%0d alu_b", d), o_alub[d], eb);
            chk16($sformatf("rnd d%0d alu_op", d), {8'd0, o_aluop[d]}, {8'd0, eo});
            for (int p = 0; p < 2; p++) begin
                chk1($sformatf("rnd d%0d resp%0d_valid", d, p), o_rv[d][p], m_v[d][p]);
                chk32($sformatf("rnd d%0d resp%0d_result", d, p), o_res[d][p], m_r[d][p]);
            end
            chk16($sformatf("rnd d%0d conflict_cnt", d), o_cnt[d], 16'(m_cnt[d]));
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int g;
            bit both;
            g    = exp_grant(d);
            both = elig(d, 0) && elig(d, 1);
            for (int p = 0; p < 2; p++) begin
                if (g == p) begin
                    m_v[d][p] = 1'b1;
                    m_r[d][p] = alu_f(in_a[p], in_b[p], in_op[p]);
                end else if (in_rr[p]) begin
                    m_v[d][p] = 1'b0;
                end
            end
            if (g >= 0) m_pref[d] = 1 - g;
            if (both && m_cnt[d] < 65535) m_cnt[d]++;
        end
    endtask

    task automatic set_idle();
        for (int p = 0; p < 2; p++) begin
            in_v[p] = 1'b0; in_a[p] = 32'd0; in_b[p] = 32'd0; in_op[p] = 8'd0; in_rr[p] = 1'b1;
        end
    endtask

    // called at a falling edge; returns at a falling edge with rst released
    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        rst_before;
        logic        v0;
        logic [31:0] a0, b0;
        logic [7:0]  op0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [7:0]  op1;
        logic        rr0, rr1;
        logic        e_rdy0, e_rdy1, e_rv0;
        logic [31:0] e_res0;
        logic        e_rv1;
        logic [31:0] e_res1;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input int rs, input int v0, input int a0, input int b0, input int op0,
                                input int v1, input int a1, input int b1, input int op1,
                                input int rr0, input int rr1, input int er0, input int er1,
                                input int ev0, input int eres0, input int ev1, input int eres1, input int ecnt);
        vec_t v;
        v.rst_before = (rs != 0);
        v.v0 = (v0 != 0); v.a0 = a0; v.b0 = b0; v.op0 = 8'(op0);
        v.v1 = (v1 != 0); v.a1 = a1; v.b1 = b1; v.op1 = 8'(op1);
        v.rr0 = (rr0 != 0); v.rr1 = (rr1 != 0);
        v.e_rdy0 = (er0 != 0); v.e_rdy1 = (er1 != 0);
        v.e_rv0 = (ev0 != 0); v.e_res0 = eres0;
        v.e_rv1 = (ev1 != 0); v.e_res1 = eres1;
        v.e_cnt = 16'(ecnt);
        return v;
    endfunction

    vec_t tbl [11];

    initial begin
        //               rs v0 a0  b0 op v1  a1  b1 op rr0 rr1 rdy0 rdy1 rv0 res0 rv1 res1        cnt
        tbl[0]  = mk(1, 1, 11, 12, 0, 0, 0,   0,  0, 1, 1, 1, 0, 0, 0,  0, 0,           0);
        tbl[1]  = mk(0, 0, 0,  0,  0, 0, 0,   0,  0, 1, 1, 0, 0, 1, 23, 0, 0,           0);
        tbl[2]  = mk(1, 1, 1,  2,  0, 1, 10,  3,  1, 1, 1, 1, 0, 0, 0,  0, 0,           0);
        tbl[3]  = mk(0, 1, 1,  2,  0, 1, 10,  3,  1, 1, 1, 0, 1, 1, 3,  0, 0,           1);
        tbl[4]  = mk(0, 1, 1,  2,  0, 1, 10,  3,  1, 1, 1, 1, 0, 0, 3,  1, 7,           2);
        tbl[5]  = mk(0, 1, 1,  2,  0, 1, 10,  3,  1, 1, 1, 0, 1, 1, 3,  0, 7,           3);
        tbl[6]  = mk(1, 1, 15, 12, 1, 0, 0,   0,  0, 0, 1, 1, 0, 0, 0,  0, 0,           0);
        tbl[7]  = mk(0, 1, 20, 5,  1, 1, -20, 12, 0, 0, 1, 0, 1, 1, 3,  0, 0,           0);
        tbl[8]  = mk(0, 1, 20, 5,  1, 0, 0,   0,  0, 0, 1, 0, 0, 1, 3,  1, 32'hFFFFFFF8, 0);
        tbl[9]  = mk(0, 1, 20, 5,  1, 0, 0,   0,  0, 1, 1, 1, 0, 1, 3,  0, 32'hFFFFFFF8, 0);
        tbl[10] = mk(0, 0, 0,  0,  0, 0, 0,   0,  0, 1, 1, 0, 0, 1, 15, 0, 32'hFFFFFFF8, 0);

        rst = 1'b1;
        set_idle();
        model_reset();
        @(negedge clk);
        // requests present while reset is held must not be granted
        in_v[0] = 1'b1; in_v[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("reset d%0d req0_ready", d), o_rdy[d][0], 1'b0);
            chk1($sformatf("reset d%0d req1_ready", d), o_rdy[d][1], 1'b0);
            chk1($sformatf("reset d%0d resp0_valid", d), o_rv[d][0], 1'b0);
            chk1($sformatf("reset d%0d resp1_valid", d), o_rv[d][1], 1'b0);
            chk32($sformatf("reset d%0d resp0_result", d), o_res[d][0], 32'd0);
            chk16($sformatf("reset d%0d conflict_cnt", d), o_cnt[d], 16'd0);
            chk32($sformatf("reset d%0d alu_a", d), o_alua[d], 32'd0);
        end
        @(negedge clk);

        // directed vectors on the round-robin instance
        for (int i = 0; i < 11; i++) begin
            logic [31:0] ea;
            if (tbl[i].rst_before) do_reset();
            in_v[0] = tbl[i].v0; in_a[0] = tbl[i].a0; in_b[0] = tbl[i].b0; in_op[0] = tbl[i].op0;
            in_v[1] = tbl[i].v1; in_a[1] = tbl[i].a1; in_b[1] = tbl[i].b1; in_op[1] = tbl[i].op1;
            in_rr[0] = tbl[i].rr0; in_rr[1] = tbl[i].rr1;
            #1;
            ea = tbl[i].e_rdy0 ? tbl[i].a0 : (tbl[i].e_rdy1 ? tbl[i].a1 : 32'd0);
            chk1($sformatf("vec%0d req0_ready", i), o_rdy[0][0], tbl[i].e_rdy0);
            chk1($sformatf("vec%0d req1_ready", i), o_rdy[0][1], tbl[i].e_rdy1);
            chk1($sformatf("vec%0d resp0_valid", i), o_rv[0][0], tbl[i].e_rv0);
            chk32($sformatf("vec%0d resp0_result", i), o_res[0][0], tbl[i].e_res0);
            chk1($sformatf("vec%0d resp1_valid", i), o_rv[0][1], tbl[i].e_rv1);
            chk32($sformatf("vec%0d resp1_result", i), o_res[0][1], tbl[i].e_res1);
            chk16($sformatf("vec%0d conflict_cnt", i), o_cnt[0], tbl[i].e_cnt);
            chk32($sformatf("vec%0d alu_a", i), o_alua[0], ea);
            @(posedge clk);
            @(negedge clk);
        end

        // fixed priority: port0 wins every contended cycle, round-robin alternates
        do_reset();
        in_v[0] = 1'b1; in_a[0] = 32'd4; in_b[0] = 32'd4; in_op[0] = 8'd0;
        in_v[1] = 1'b1; in_a[1] = 32'd9; in_b[1] = 32'd1; in_op[1] = 8'd1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk1($sformatf("fixed c%0d req0_ready", i), o_rdy[1][0], 1'b1);
            chk1($sformatf("fixed c%0d req1_ready", i), o_rdy[1][1], 1'b0);
            chk1($sformatf("fixed c%0d resp1_valid", i), o_rv[1][1], 1'b0);
            chk1($sformatf("rr c%0d req0_ready", i), o_rdy[0][0], (i % 2) == 0);
            chk16($sformatf("fixed c%0d conflict_cnt", i), o_cnt[1], 16'(i));
            @(posedge clk);
            @(negedge clk);
        end

        // async reset mid-burst drops a held response without a clock edge
        do_reset();
        in_v[0] = 1'b1; in_a[0] = 32'd5; in_b[0] = 32'd6; in_op[0] = 8'd0; in_rr[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_v[0] = 1'b0;
        #1;
        chk1("async pre resp0_valid", o_rv[0][0], 1'b1);
        chk32("async pre resp0_result", o_res[0][0], 32'd11);
        #1;
        rst = 1'b1;
        in_v[0] = 1'b1; in_v[1] = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("async d%0d resp0_valid", d), o_rv[d][0], 1'b0);
            chk32($sformatf("async d%0d resp0_result", d), o_res[d][0], 32'd0);
            chk1($sformatf("async d%0d req0_ready", d), o_rdy[d][0], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        in_rr[0] = 1'b1; in_rr[1] = 1'b1;
        #1;
        chk1("async post req0_ready", o_rdy[0][0], 1'b1);
        chk1("async post req1_ready", o_rdy[0][1], 1'b0);
        @(posedge clk);
        @(negedge clk);

        // randomized traffic against the reference model, both instances
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                in_v[p]  = ($urandom_range(0, 3) != 0);
                in_rr[p] = ($urandom_range(0, 2) != 0);
                in_a[p]  = $urandom;
                in_b[p]  = $urandom;
                in_op[p] = 8'($urandom_range(0, 6));
            end
            #1;
            model_check();
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        // conflict counter saturation
        do_reset();
        in_v[0] = 1'b1; in_v[1] = 1'b1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk16("sat rr cnt at 65534", o_cnt[0], 16'hFFFE);
        chk16("sat fp cnt at 65534", o_cnt[1], 16'hFFFE);
        @(posedge clk);
        @(negedge clk);
        chk16("sat rr cnt at 65535", o_cnt[0], 16'hFFFF);
        repeat (4500) @(posedge clk);
        @(negedge clk);
        chk16("sat rr cnt held", o_cnt[0], 16'hFFFF);
        chk16("sat fp cnt held", o_cnt[1], 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
